// File: rtl/mau_pkg.sv
// mau_pkg: shared types and constants for the data-memory access unit.
//   mau_state_e : controller FSM state encoding
//   SZ_*        : request size encoding (2'b11 is handled as a word)
//   norm_size   : folds the reserved size code onto SZ_WORD
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LD_WAIT   = 2'd1,
    RMW_MERGE = 2'd2,
    RESP      = 2'd3
  } mau_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/mau_if.sv
// mau_if: request/response handshake plus the word-wide memory port.
//   slave  : the access unit (accepts requests, drives the memory port)
//   master : pipeline memory stage and the memory itself
// Params: INDEX_W memory word-index width, THREAD_W thread tag width.
interface mau_if #(
  parameter int INDEX_W  = 7,
  parameter int THREAD_W = 2
);
  logic                ReqValid;
  logic                ReqReady;
  logic                ReqWrite;
  logic [1:0]          ReqSize;
  logic                ReqUnsigned;
  logic [31:0]         ReqAddr;
  logic [31:0]         ReqWData;
  logic [THREAD_W-1:0] ReqTid;

  logic                RespValid;
  logic [31:0]         RespData;
  logic [THREAD_W-1:0] RespTid;
  logic                RespErr;

  logic                WriteCache;
  logic                ReadEnable;
  logic [INDEX_W-1:0]  CacheIndexWrite;
  logic [INDEX_W-1:0]  CacheIndexRead;
  logic [31:0]         WriteDataCache;
  logic [31:0]         CacheData;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, ReqTid,
    input  CacheData,
    output ReqReady,
    output RespValid, RespData, RespTid, RespErr,
    output WriteCache, ReadEnable, CacheIndexWrite, CacheIndexRead, WriteDataCache
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, ReqTid,
    output CacheData,
    input  ReqReady,
    input  RespValid, RespData, RespTid, RespErr,
    input  WriteCache, ReadEnable, CacheIndexWrite, CacheIndexRead, WriteDataCache
  );
endinterface

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational little-endian lane handling.
//   i_word     : word read from memory
//   i_off      : byte offset within the word (addr[1:0])
//   i_size     : normalised access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   i_unsigned : zero-extend sub-word loads
//   i_new      : store data (low byte or half is used)
//   o_load     : extracted and extended load result
//   o_merged   : i_word with the addressed lane replaced by i_new
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [15:0] i_new,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[{i_off, 3'b000} +: 8];
    // Half lane is chosen by addr[1] only; addr[0] is ignored here.
    w_half   = i_off[1] ? i_word[31:16] : i_word[15:0];
    o_load   = i_word;
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_merged[{i_off, 3'b000} +: 8] = i_new[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
        if (i_off[1]) o_merged[31:16] = i_new;
        else          o_merged[15:0]  = i_new;
      end
      default: begin
        o_load   = i_word;
        o_merged = i_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: serialised load/store controller for the word-wide data
// memory. Sub-word stores use read-modify-write since the memory has no
// byte enables. One thread-tagged response pulse per accepted request.
//   i_clk : clock
//   i_rst : asynchronous active-high reset
//   bus   : mau_if.slave (request/response handshake + memory port)
// Optional feature: MAU_MISALIGN_TRAP_EN -- misaligned half/word accesses
// skip memory and respond immediately with RespErr = 1.
//
// state     | meaning
// IDLE      | ready; accept launches read or word write
// LD_WAIT   | memory data present; extract and extend load lane
// RMW_MERGE | write back old word with the new lane merged in
// RESP      | one-cycle response pulse
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int INDEX_W  = 7,
  parameter int THREAD_W = 2
) (
  input logic i_clk,
  input logic i_rst,
  mau_if.slave bus
);

  mau_state_e          r_state, w_next;
  logic [INDEX_W-1:0]  r_index;
  logic [1:0]          r_off;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [15:0]         r_wdata;
  logic [THREAD_W-1:0] r_tid;

  logic                r_resp_valid;
  logic [31:0]         r_resp_data;
  logic [THREAD_W-1:0] r_resp_tid;
  logic                r_resp_err;

  logic [1:0]          w_size;
  logic                w_word;
  logic                w_accept;
  logic                w_misalign;
  logic [INDEX_W-1:0]  w_req_index;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;
  logic                w_unused_addr;

  assign w_size        = norm_size(bus.ReqSize);
  assign w_word        = (w_size == SZ_WORD);
  assign w_req_index   = bus.ReqAddr[INDEX_W+1:2];
  assign w_unused_addr = ^bus.ReqAddr[31:INDEX_W+2];
  assign w_accept      = bus.ReqValid && (r_state == IDLE) && !i_rst;

`ifdef MAU_MISALIGN_TRAP_EN
  assign w_misalign = ((w_size == SZ_HALF) && bus.ReqAddr[0]) ||
                      (w_word && (bus.ReqAddr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  mau_lane_align u_lane (
    .i_word     (bus.CacheData),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_new      (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_misalign)        w_next = RESP;
          else if (!bus.ReqWrite) w_next = LD_WAIT;
          else if (w_word)       w_next = RESP;
          else                   w_next = RMW_MERGE;
        end
      end
      LD_WAIT:   w_next = RESP;
      RMW_MERGE: w_next = RESP;
      RESP:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ReqReady        = 1'b0;
    bus.ReadEnable      = 1'b0;
    bus.WriteCache      = 1'b0;
    bus.CacheIndexRead  = w_req_index;
    bus.CacheIndexWrite = r_index;
    bus.WriteDataCache  = w_merged;
    case (r_state)
      IDLE: begin
        bus.ReqReady = !i_rst;
        if (w_accept && !w_misalign) begin
          if (bus.ReqWrite && w_word) begin
            bus.WriteCache      = 1'b1;
            bus.CacheIndexWrite = w_req_index;
            bus.WriteDataCache  = bus.ReqWData;
          end else begin
            // Loads and sub-word stores both start with a read.
            bus.ReadEnable = 1'b1;
          end
        end
      end
      RMW_MERGE: bus.WriteCache = !i_rst;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_index    <= '0;
      r_off      <= '0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_tid      <= '0;
    end else if (w_accept) begin
      r_index    <= w_req_index;
      r_off      <= bus.ReqAddr[1:0];
      r_size     <= w_size;
      r_unsigned <= bus.ReqUnsigned;
      r_wdata    <= bus.ReqWData[15:0];
      r_tid      <= bus.ReqTid;
    end
  end

  // Response fields are non-zero only during the RESP cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tid   <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= (w_next == RESP);
      r_resp_data  <= '0;
      r_resp_tid   <= '0;
      r_resp_err   <= 1'b0;
      if (w_next == RESP) begin
        if (r_state == IDLE) begin
          r_resp_tid <= bus.ReqTid;
          r_resp_err <= w_misalign;
        end else begin
          r_resp_tid <= r_tid;
        end
        if (r_state == LD_WAIT) r_resp_data <= w_load;
      end
    end
  end

  assign bus.RespValid = r_resp_valid;
  assign bus.RespData  = r_resp_data;
  assign bus.RespTid   = r_resp_tid;
  assign bus.RespErr   = r_resp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int INDEX_W  = 7;
  localparam int THREAD_W = 2;
  localparam int DEPTH    = 1 << INDEX_W;
`ifdef MAU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mau_if #(.INDEX_W(INDEX_W), .THREAD_W(THREAD_W)) bus ();

  mem_access_unit #(.INDEX_W(INDEX_W), .THREAD_W(THREAD_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Memory environment with a side port for preloading.
  logic [31:0]        mem [DEPTH];
  logic               pl_en = 1'b0;
  logic [INDEX_W-1:0] pl_idx = '0;
  logic [31:0]        pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.WriteCache) mem[bus.CacheIndexWrite] <= bus.WriteDataCache;
    if (bus.ReadEnable) bus.CacheData <= mem[bus.CacheIndexRead];
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: memory image plus a queue of expected responses.
  typedef struct {
    int                  due;
    logic [31:0]         data;
    logic [THREAD_W-1:0] tid;
    logic                err;
    bit                  wr;
    int                  idx;
    logic [31:0]         wval;
    int                  rd_n;
    int                  wr_n;
  } exp_t;

  logic [31:0] ref_mem [DEPTH];
  exp_t q[$];

  function automatic exp_t predict(input logic wr, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [THREAD_W-1:0] tid, input int now);
    exp_t e;
    int nbytes, sh, off;
    logic [31:0] w, mask, v;
    e.idx  = int'(addr[INDEX_W+1:2]);
    w      = ref_mem[e.idx];
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off    = int'(addr[1:0]);
    e.tid = tid; e.err = 1'b0; e.data = '0; e.wr = 0; e.wval = '0; e.rd_n = 0; e.wr_n = 0;
    if (TRAP && (off % nbytes) != 0) begin
      e.err = 1'b1;
      e.due = now + 1;
      return e;
    end
    sh   = (nbytes == 4) ? 0 : 8 * ((off / nbytes) * nbytes);
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    if (!wr) begin
      v = (w >> sh) & mask;
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      e.data = v;
      e.due  = now + 2;
      e.rd_n = 1;
    end else begin
      e.wr   = 1;
      e.wval = (w & ~(mask << sh)) | ((wd & mask) << sh);
      e.due  = now + ((nbytes == 4) ? 1 : 2);
      e.rd_n = (nbytes < 4) ? 1 : 0;
      e.wr_n = 1;
    end
    return e;
  endfunction

  int cyc = 0, busy_until = 0;
  int rd_act = 0, wr_act = 0, rd_exp = 0, wr_exp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (pl_en) ref_mem[pl_idx] = pl_data;
    if (rst) begin
      q.delete();
      busy_until = cyc;
      rd_act = 0; wr_act = 0; rd_exp = 0; wr_exp = 0;
    end else begin
      if (bus.ReadEnable) rd_act++;
      if (bus.WriteCache) wr_act++;
      check("ReqReady", {31'd0, bus.ReqReady}, {31'd0, cyc >= busy_until});
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.wr) ref_mem[e.idx] = e.wval;
        check("RespValid", {31'd0, bus.RespValid}, 32'd1);
        check("RespData", bus.RespData, e.data);
        check("RespTid", {30'd0, bus.RespTid}, {30'd0, e.tid});
        check("RespErr", {31'd0, bus.RespErr}, {31'd0, e.err});
        check("mem_word", mem[e.idx], ref_mem[e.idx]);
        check("read_strobes", rd_act, rd_exp);
        check("write_strobes", wr_act, wr_exp);
      end else begin
        check("RespValid_idle", {31'd0, bus.RespValid}, 32'd0);
      end
      if (bus.ReqValid && bus.ReqReady) begin
        e = predict(bus.ReqWrite, bus.ReqSize, bus.ReqUnsigned, bus.ReqAddr,
                    bus.ReqWData, bus.ReqTid, cyc);
        q.push_back(e);
        busy_until = e.due + 1;
        rd_exp += e.rd_n;
        wr_exp += e.wr_n;
      end
    end
    cyc++;
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = INDEX_W'(idx); pl_data = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] tid,
                        output logic [31:0] data, output logic [1:0] rtid, output logic err,
                        output int lat, output logic re0, output logic we0,
                        output logic [INDEX_W-1:0] widx0, output logic we1,
                        output logic [31:0] wd1);
    int n;
    @(posedge clk); #1;
    bus.ReqWrite = wr; bus.ReqSize = sz; bus.ReqUnsigned = uns;
    bus.ReqAddr = addr; bus.ReqWData = wd; bus.ReqTid = tid; bus.ReqValid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ReqReady && n < 20);
    re0 = bus.ReadEnable; we0 = bus.WriteCache; widx0 = bus.CacheIndexWrite;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    lat = 0; data = '0; rtid = '0; err = 1'b0; we1 = 1'b0; wd1 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin we1 = bus.WriteCache; wd1 = bus.WriteDataCache; end
      if (bus.RespValid) begin
        lat = k; data = bus.RespData; rtid = bus.RespTid; err = bus.RespErr;
        break;
      end
    end
  endtask

  logic [31:0]        r_data, r_wd1;
  logic [1:0]         r_tid;
  logic               r_err, r_re0, r_we0, r_we1;
  logic [INDEX_W-1:0] r_widx0;
  int                 r_lat;
  int                 acc, rd, wr;
  bit                 accepted;

  initial begin
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'b00; bus.ReqUnsigned = 1'b0;
    bus.ReqAddr = '0; bus.ReqWData = '0; bus.ReqTid = '0;

    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

    // Reset state, with a request offered to show gating.
    bus.ReqValid = 1'b1;
    @(negedge clk);
    check("rst_ReqReady", {31'd0, bus.ReqReady}, 32'd0);
    check("rst_ReadEnable", {31'd0, bus.ReadEnable}, 32'd0);
    check("rst_WriteCache", {31'd0, bus.WriteCache}, 32'd0);
    check("rst_RespValid", {31'd0, bus.RespValid}, 32'd0);
    check("rst_RespData", bus.RespData, 32'd0);
    check("rst_RespTid", {30'd0, bus.RespTid}, 32'd0);
    check("rst_RespErr", {31'd0, bus.RespErr}, 32'd0);
    bus.ReqValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Byte loads, signed and unsigned.
    preload(5, 32'h8899_AABB);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h15, 32'h0, 2'd1, r_data, r_tid, r_err, r_lat, r_re0, r_we0, r_widx0, r_we1, r_wd1);
    check("lb_data", r_data, 32'hFFFF_FFAA);
    check("lb_tid", {30'd0, r_tid}, 32'd1);
    check("lb_lat", r_lat, 2);
    check("lb_read0", {31'd0, r_re0}, 32'd1);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h15, 32'h0, 2'd2, r_data, r_tid, r_err, r_lat, r_re0, r_we0, r_widx0, r_we1, r_wd1);
    check("lbu_data", r_data, 32'h0000_00AA);
    check("lbu_tid", {30'd0, r_tid}, 32'd2);

    // Word store then word load back.
    do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1234_5678, 2'd3, r_data, r_tid, r_err, r_lat, r_re0, r_we0, r_widx0, r_we1, r_wd1);
    check("sw_write0", {31'd0, r_we0}, 32'd1);
    check("sw_index", {25'd0, r_widx0}, 32'd8);
    check("sw_lat", r_lat, 1);
    check("sw_tid", {30'd0, r_tid}, 32'd3);
    check("sw_data", r_data, 32'd0);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 2'd0, r_data, r_tid, r_err, r_lat, r_re0, r_we0, r_widx0, r_we1, r_wd1);
    check("lw_data", r_data, 32'h1234_5678);

    // Halfword store via read-modify-write.
    do_req(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_BEEF, 2'd1, r_data, r_tid, r_err, r_lat, r_re0, r_we0, r_widx0, r_we1, r_wd1);
    check("sh_read0", {31'd0, r_re0}, 32'd1);
    check("sh_write0", {31'd0, r_we0}, 32'd0);
    check("sh_write1", {31'd0, r_we1}, 32'd1);
    check("sh_wdata1", r_wd1, 32'hBEEF_5678);
    check("sh_lat", r_lat, 2);
    check("sh_mem", mem[8], 32'hBEEF_5678);

    // ReqValid held high across back-to-back loads.
    @(posedge clk); #1;
    bus.ReqWrite = 1'b0; bus.ReqSize = SZ_WORD; bus.ReqAddr = 32'h20; bus.ReqTid = 2'd0;
    bus.ReqValid = 1'b1;
    acc = 0; rd = 0; wr = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (bus.ReqValid && bus.ReqReady) acc++;
      if (bus.ReadEnable) rd++;
      if (bus.WriteCache) wr++;
    end
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    check("held_accepts", acc, 3);
    check("held_reads", rd, 3);
    check("held_writes", wr, 0);

    // Reset while the merge write is pending.
    preload(10, 32'hCAFE_F00D);
    @(posedge clk); #1;
    bus.ReqWrite = 1'b1; bus.ReqSize = SZ_BYTE; bus.ReqAddr = 32'h29; bus.ReqWData = 32'h55;
    bus.ReqTid = 2'd1; bus.ReqValid = 1'b1;
    @(negedge clk);
    check("rmw_ready", {31'd0, bus.ReqReady}, 32'd1);
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    check("rmw_write_pending", {31'd0, bus.WriteCache}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rmw_rst_WriteCache", {31'd0, bus.WriteCache}, 32'd0);
    check("rmw_rst_ReqReady", {31'd0, bus.ReqReady}, 32'd0);
    check("rmw_rst_RespValid", {31'd0, bus.RespValid}, 32'd0);
    check("rmw_rst_RespData", bus.RespData, 32'd0);
    check("rmw_rst_RespTid", {30'd0, bus.RespTid}, 32'd0);
    check("rmw_rst_RespErr", {31'd0, bus.RespErr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rmw_idle_after", {31'd0, bus.ReqReady}, 32'd1);
    check("rmw_mem_kept", mem[10], 32'hCAFE_F00D);

    // Misaligned word load.
    preload(4, 32'h0102_0304);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 2'd2, r_data, r_tid, r_err, r_lat, r_re0, r_we0, r_widx0, r_we1, r_wd1);
    if (TRAP) begin
      check("mis_err", {31'd0, r_err}, 32'd1);
      check("mis_lat", r_lat, 1);
      check("mis_noread", {31'd0, r_re0}, 32'd0);
      check("mis_data", r_data, 32'd0);
    end else begin
      check("mis_err", {31'd0, r_err}, 32'd0);
      check("mis_lat", r_lat, 2);
      check("mis_data", r_data, 32'h0102_0304);
    end

    // Randomised traffic; a pending request is held until accepted.
    @(posedge clk); #1;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      accepted = bus.ReqValid && bus.ReqReady;
      @(posedge clk); #1;
      if (!bus.ReqValid || accepted) begin
        bus.ReqValid    = ($urandom_range(0, 9) < 7);
        bus.ReqWrite    = $urandom_range(0, 1) == 1;
        bus.ReqSize     = 2'($urandom_range(0, 3));
        bus.ReqUnsigned = $urandom_range(0, 1) == 1;
        bus.ReqAddr     = $urandom;
        bus.ReqWData    = $urandom;
        bus.ReqTid      = 2'($urandom_range(0, 3));
      end
    end
    bus.ReqValid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
